// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ctrl_pkg
// Description : Shared types and mode constants for the SPI master slave-select
//               and frame-timing control logic.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;

endpackage
`default_nettype wire

// File: rtl/spi_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_timer
// Description : Clearable up-counter that flags when it reaches a terminal value.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_timer #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_terminal
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_terminal = (r_cnt == i_term);

endmodule
`default_nettype wire

// File: rtl/spi_multi_ss_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_multi_ss_frame_ctrl
// Description : Master-side multi slave-select and frame-timing controller with
//               SS setup/hold guard cycles and frame-complete pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_multi_ss_frame_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int  NUM_SS    = 4,
    parameter int  BRD_W     = 12,
    parameter int  MAX_FRAME = 16,
    parameter int  SETUP_CYC = 1,
    parameter int  HOLD_CYC  = 1,
    localparam int SEL_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
    localparam int FB_W      = $clog2(MAX_FRAME) + 1,
    localparam int CNT_W     = BRD_W + $clog2(MAX_FRAME) + 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              mstr,
    input  logic              spiswai,
    input  logic [1:0]        spi_mode,
    input  logic              send_data,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic [FB_W-1:0]   frame_bits,
    input  logic [BRD_W-1:0]  baudratedivisor,
    output logic [NUM_SS-1:0] ss_n,
    output logic              tip,
    output logic              receive_data,
    output logic              req_err
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [FB_W-1:0]    r_bits;
    logic [BRD_W-1:0]   r_brd;
    logic [NUM_SS-1:0]  r_ss_n;
    logic               r_rx;
    logic               r_err;

    logic               w_enable;
    logic               w_illegal;
    logic               w_accept;
    logic               w_rx_nxt;
    logic               w_err_nxt;
    logic               w_clr;
    logic               w_terminal;
    logic [CNT_W-1:0]   w_xfer_len;
    logic [CNT_W-1:0]   w_term;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [NUM_SS-1:0]  w_ss_n_nxt;

    assign w_enable  = mstr && !spiswai && ((spi_mode == SPI_RUN) || (spi_mode == SPI_WAIT));
    assign w_illegal = (32'(ss_sel) >= NUM_SS) || (frame_bits == '0) ||
                       (32'(frame_bits) > MAX_FRAME) || (baudratedivisor == '0);

    // Two PCLK edges per bit, brd cycles per half-period, from the latched operands.
    assign w_xfer_len = (CNT_W'(r_brd) * CNT_W'(r_bits)) << 1;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rx_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_enable && send_data) begin
                    if (w_illegal) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = (SETUP_CYC > 0) ? ST_SETUP : ST_XFER;
                    end
                end
            end
            ST_SETUP: begin
                if (!w_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_terminal) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!w_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_terminal) begin
                    w_rx_nxt    = 1'b1;
                    w_state_nxt = (HOLD_CYC > 0) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!w_enable || w_terminal) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_term = '0;
        case (r_state)
            ST_SETUP: w_term = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
            ST_XFER:  w_term = w_xfer_len - 1'b1;
            ST_HOLD:  w_term = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
            default:  w_term = '0;
        endcase
    end

    // Every phase starts counting from zero; the counter idles at zero.
    assign w_clr      = (w_state_nxt != r_state) || (r_state == ST_IDLE);
    assign w_sel_nxt  = w_accept ? ss_sel : r_sel;
    assign w_ss_n_nxt = (w_state_nxt == ST_IDLE) ? {NUM_SS{1'b1}}
                                                 : ~(NUM_SS'(1) << w_sel_nxt);

    spi_frame_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (PCLK),
        .rst        (PRESET),
        .i_clr      (w_clr),
        .i_run      (1'b1),
        .i_term     (w_term),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_bits  <= '0;
            r_brd   <= '0;
            r_ss_n  <= {NUM_SS{1'b1}};
            r_rx    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ss_n  <= w_ss_n_nxt;
            r_rx    <= w_rx_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_sel  <= ss_sel;
                r_bits <= frame_bits;
                r_brd  <= baudratedivisor;
            end
        end
    end

    assign ss_n         = r_ss_n;
    assign tip          = ~(&r_ss_n);
    assign receive_data = r_rx;
    assign req_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_multi_ss_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_multi_ss_frame_ctrl
// Description : Self-checking bench; two instances (guards 1/1 and 0/0) compared
//               against a timestamp-based frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_multi_ss_frame_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        mstr, spiswai, send_data;
    logic [1:0]  spi_mode;
    logic [1:0]  ss_sel;
    logic [4:0]  frame_bits;
    logic [11:0] baudratedivisor;

    logic [3:0]  ss_n0, ss_n1;
    logic        tip0, tip1, rx0, rx1, err0, err1;

    spi_multi_ss_frame_ctrl #(.SETUP_CYC(1), .HOLD_CYC(1)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .mstr(mstr), .spiswai(spiswai), .spi_mode(spi_mode),
        .send_data(send_data), .ss_sel(ss_sel), .frame_bits(frame_bits),
        .baudratedivisor(baudratedivisor), .ss_n(ss_n0), .tip(tip0),
        .receive_data(rx0), .req_err(err0));

    spi_multi_ss_frame_ctrl #(.SETUP_CYC(0), .HOLD_CYC(0)) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .mstr(mstr), .spiswai(spiswai), .spi_mode(spi_mode),
        .send_data(send_data), .ss_sel(ss_sel), .frame_bits(frame_bits),
        .baudratedivisor(baudratedivisor), .ss_n(ss_n1), .tip(tip1),
        .receive_data(rx1), .req_err(err1));

    always #5 PCLK = ~PCLK;

    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;

    // Frame model: each accepted request occupies an interval of cycles.
    longint m_start [2];
    longint m_end   [2];
    longint m_rxat  [2];
    longint m_errat [2];
    bit     m_rxv   [2];
    int     m_sel   [2];
    int     g_setup [2] = '{1, 0};
    int     g_hold  [2] = '{1, 0};

    int lowc, rxc, errc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_start[i] = 0;
            m_end[i]   = -1;
            m_rxat[i]  = -1;
            m_errat[i] = -1;
            m_rxv[i]   = 1'b0;
            m_sel[i]   = 0;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ss0"}, 32'(ss_n0), 32'hF);
        chk({tag, "_tip0"}, 32'(tip0), 0);
        chk({tag, "_rx0"}, 32'(rx0), 0);
        chk({tag, "_err0"}, 32'(err0), 0);
        chk({tag, "_ss1"}, 32'(ss_n1), 32'hF);
        chk({tag, "_tip1"}, 32'(tip1), 0);
    endtask

    task automatic step();
        bit     en, busy, bad;
        longint t;
        logic [3:0] one, e_ss, o_ss;
        logic   low, o_tip, o_rx, o_err;
        @(posedge PCLK);
        cyc++;
        en  = mstr && !spiswai && (spi_mode == 2'b00 || spi_mode == 2'b01);
        bad = (frame_bits == 0) || (frame_bits > 16) || (baudratedivisor == 0);
        for (int i = 0; i < 2; i++) begin
            busy = (cyc - 1 >= m_start[i]) && (cyc - 1 <= m_end[i]);
            if (!en) begin
                if (busy) begin
                    m_end[i] = cyc - 1;
                    if (m_rxv[i] && m_rxat[i] >= cyc) m_rxv[i] = 1'b0;
                end
            end else if (send_data && !busy) begin
                if (bad) begin
                    m_errat[i] = cyc;
                end else begin
                    t          = 2 * longint'(baudratedivisor) * longint'(frame_bits);
                    m_sel[i]   = int'(ss_sel);
                    m_start[i] = cyc;
                    m_end[i]   = cyc + g_setup[i] + t + g_hold[i] - 1;
                    m_rxat[i]  = cyc + g_setup[i] + t;
                    m_rxv[i]   = 1'b1;
                end
            end
        end
        @(negedge PCLK);
        for (int i = 0; i < 2; i++) begin
            low   = (cyc >= m_start[i]) && (cyc <= m_end[i]);
            one   = 4'b0001 << m_sel[i];
            e_ss  = low ? ~one : 4'hF;
            o_ss  = (i == 0) ? ss_n0 : ss_n1;
            o_tip = (i == 0) ? tip0 : tip1;
            o_rx  = (i == 0) ? rx0 : rx1;
            o_err = (i == 0) ? err0 : err1;
            chk($sformatf("ss_n%0d@%0d", i, cyc), 32'(o_ss), 32'(e_ss));
            chk($sformatf("tip%0d@%0d", i, cyc), 32'(o_tip), 32'(low));
            chk($sformatf("rx%0d@%0d", i, cyc), 32'(o_rx), 32'(m_rxv[i] && m_rxat[i] == cyc));
            chk($sformatf("err%0d@%0d", i, cyc), 32'(o_err), 32'(m_errat[i] == cyc));
        end
    endtask

    task automatic count_steps(input int n);
        lowc = 0; rxc = 0; errc = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (ss_n0 != 4'hF) lowc++;
            if (rx0) rxc++;
            if (err0) errc++;
        end
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic async_reset();
        #2 PRESET = 1'b1;
        #1 chk_reset_vals("async_rst");
        model_clear();
        @(posedge PCLK);
        cyc++;
        @(negedge PCLK);
        chk_reset_vals("rst_hold");
        PRESET = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; mstr = 1'b0; spiswai = 1'b0; spi_mode = 2'b00; send_data = 1'b0;
        ss_sel = 2'd0; frame_bits = 5'd8; baudratedivisor = 12'd2;
        model_clear();
        #1 chk_reset_vals("reset");
        @(posedge PCLK); cyc++;
        @(negedge PCLK);
        chk_reset_vals("reset2");
        PRESET = 1'b0;
        mstr = 1'b1;
        repeat (2) step();

        // Basic frame on slave 1.
        ss_sel = 2'd1; baudratedivisor = 12'd2; frame_bits = 5'd8; send_data = 1'b1;
        step();
        chk("t1_first_ss", 32'(ss_n0), 32'hD);
        lowc = 1;
        send_data = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (ss_n0 != 4'hF) lowc++;
            if (rx0) rxc++;
        end
        chk("t1_low_cycles", 32'(lowc), 34);

        // Illegal requests.
        baudratedivisor = 12'd0; send_data = 1'b1;
        step(); send_data = 1'b0;
        count_steps(3);
        chk("t2_err_after", 32'(errc), 0);
        baudratedivisor = 12'd2; frame_bits = 5'd0; send_data = 1'b1;
        step(); chk("t2_err_bits0", 32'(err0), 1); send_data = 1'b0;
        frame_bits = 5'd17; send_data = 1'b1;
        step(); step(); send_data = 1'b0;
        count_steps(2);
        chk("t2_no_tip", 32'(tip0), 0);

        // Abort during XFER cycle 10.
        frame_bits = 5'd8; ss_sel = 2'd2; send_data = 1'b1;
        step(); send_data = 1'b0;
        repeat (11) step();
        spiswai = 1'b1;
        step();
        chk("t3_abort_ss", 32'(ss_n0), 32'hF);
        spiswai = 1'b0;
        count_steps(40);
        chk("t3_no_rx", 32'(rxc), 0);
        send_data = 1'b1;
        step(); send_data = 1'b0;
        lowc = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (ss_n0 != 4'hF) lowc++;
        end
        chk("t3_full_frame", 32'(lowc), 34);

        // Mid-frame request and operand changes are ignored.
        ss_sel = 2'd3; frame_bits = 5'd8; send_data = 1'b1;
        step(); send_data = 1'b0;
        repeat (4) step();
        frame_bits = 5'd4; ss_sel = 2'd0; send_data = 1'b1;
        repeat (5) step();
        send_data = 1'b0;
        lowc = 10;
        for (int k = 0; k < 40; k++) begin
            step();
            if (ss_n0 != 4'hF) lowc++;
        end
        chk("t4_len", 32'(lowc), 34);

        // Back-to-back minimal frames on the guard-less instance.
        baudratedivisor = 12'd1; frame_bits = 5'd1; ss_sel = 2'd0; send_data = 1'b1;
        rxc = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (rx1) rxc++;
        end
        send_data = 1'b0;
        chk("t5_b2b_rx", 32'(rxc), 3);
        repeat (6) step();

        // Asynchronous reset mid-XFER.
        baudratedivisor = 12'd3; frame_bits = 5'd8; ss_sel = 2'd1; send_data = 1'b1;
        step(); send_data = 1'b0;
        repeat (10) step();
        async_reset();
        repeat (3) step();

        // Randomized traffic.
        for (int k = 0; k < 2500; k++) begin
            mstr            = ($urandom % 16) != 0;
            spiswai         = ($urandom % 40) == 0;
            spi_mode        = (($urandom % 20) == 0) ? 2'(2 + $urandom % 2) : 2'($urandom % 2);
            send_data       = ($urandom % 4) == 0;
            ss_sel          = 2'($urandom % 4);
            frame_bits      = (($urandom % 10) == 0) ? 5'($urandom % 32) : 5'(1 + $urandom % 6);
            baudratedivisor = (($urandom % 16) == 0) ? 12'd0 : 12'(1 + $urandom % 3);
            if (($urandom % 500) == 0) async_reset();
            else step();
        end
        send_data = 1'b0; mstr = 1'b1; spiswai = 1'b0; spi_mode = 2'b00;
        repeat (120) step();
        chk("drain_idle", 32'(tip0 | tip1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
